// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per cycle, LSB first, with a borrow chain.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic [CW-1:0]    cnt;
    logic             bw;
    logic             d_bit;
    logic             bw_next;
    logic             last_bit;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // One full-subtractor cell, reused every SHIFT cycle.
    assign d_bit    = a_sr[0] ^ b_sr[0] ^ bw;
    assign bw_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & bw);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Results are committed on the DONE->IDLE edge so diff/borrow_out stay stable
    // through the whole operation and the done pulse lines up with valid data.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            d_sr       <= '0;
            cnt        <= '0;
            bw         <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        bw   <= 1'b0;
                        cnt  <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    d_sr <= {d_bit, d_sr[WIDTH-1:1]};
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    bw   <= bw_next;
                    cnt  <= cnt + CW'(1);
                end
                DONE: begin
                    diff       <= d_sr;
                    borrow_out <= bw;
                    done       <= 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    ovf        <= (a_msb != b_msb) && (d_sr[WIDTH-1] != a_msb);
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus random operands
// checked against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic       ovf;
`endif

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_diff(input int av, input int bv);
        return 8'((av - bv + 256) % 256);
    endfunction

    function automatic logic m_borrow(input int av, input int bv);
        return av < bv;
    endfunction

    function automatic logic m_ovf(input int av, input int bv);
        int sa, sb, r;
        sa = (av > 127) ? av - 256 : av;
        sb = (bv > 127) ? bv - 256 : bv;
        r  = sa - sb;
        return (r > 127) || (r < -128);
    endfunction

    // Issue one start pulse, scramble the inputs, then wait for done and check everything.
    task automatic run_op(input int av, input int bv, input string tag);
        int lat;
        a = 8'(av); b = 8'(bv); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        check({tag, "_latency"}, 32'(lat), 32'd9);
        if (lat != 0) begin
            check({tag, "_diff"}, 32'(diff), 32'(m_diff(av, bv)));
            check({tag, "_borrow"}, 32'(borrow_out), 32'(m_borrow(av, bv)));
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf(av, bv)));
`endif
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
            check({tag, "_hold"}, 32'(diff), 32'(m_diff(av, bv)));
        end
    endtask

    initial begin
        int dones, lat, first, prev;
        logic [7:0] dsave;
        logic       bsave;
        int pulses[$];

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow_out), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(8'h05, 8'h03, "d_05_03");
        check("d_05_03_const", 32'(diff), 32'h02);
        run_op(8'h03, 8'h05, "d_03_05");
        check("d_03_05_const", 32'(diff), 32'hFE);
        run_op(8'h00, 8'h00, "d_00_00");

        // Operand change and start pulse while busy must not disturb the running op.
        a = 8'h00; b = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0; lat = 0; dsave = '0; bsave = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin a = 8'h10; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk); #1;
            if (done) begin dones++; lat = k; dsave = diff; bsave = borrow_out; end
        end
        check("busy_change_dones", 32'(dones), 32'd1);
        check("busy_change_lat", 32'(lat), 32'd9);
        check("busy_change_diff", 32'(dsave), 32'hFF);
        check("busy_change_borrow", 32'(bsave), 32'd1);

        // Reset four cycles into an operation.
        a = 8'h55; b = 8'h11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_borrow", 32'(borrow_out), 32'd0);
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        run_op(8'h09, 8'h04, "after_abort");
        check("after_abort_const", 32'(diff), 32'h05);

        // start held high: back-to-back operations.
        a = 8'h20; b = 8'h07; start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulses.push_back(i);
                check("held_diff", 32'(diff), 32'(m_diff(32'h20, 32'h07)));
            end
        end
        start = 1'b0;
        check("held_pulses", 32'(pulses.size()), 32'd3);
        if (pulses.size() > 0) begin
            first = pulses[0];
            check("held_first", 32'(first), 32'd10);
            prev = first;
            for (int i = 1; i < pulses.size(); i++) begin
                check("held_spacing", 32'(pulses[i] - prev), 32'd10);
                prev = pulses[i];
            end
        end
        repeat (12) @(posedge clk);
        #1;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        run_op(8'h80, 8'h01, "ovf_80_01");
        check("ovf_80_01_diff", 32'(diff), 32'h7F);
        check("ovf_80_01_ovf", 32'(ovf), 32'd1);
        run_op(8'h7F, 8'h01, "ovf_7f_01");
        check("ovf_7f_01_diff", 32'(diff), 32'h7E);
        check("ovf_7f_01_ovf", 32'(ovf), 32'd0);
`endif

        for (int i = 0; i < 16; i++) begin
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
